// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl
// Register-dump sequencer for the pipelined DLX core. It overrides the core's
// instruction input, drains the pipeline with NOPs, and then injects one
// register-read instruction (rs = register index) per architectural register.
// After each injection has settled, it captures the core's busA probe. Each
// (index, value) pair is offered on a valid/ready stream.
//
// Optional feature macro: DUMP_CHECKSUM_EN
//   When defined, this adds a rotate-xor running checksum of every delivered
//   value on the 'checksum' output.
//
// Ports:
//   clk           in   clock, all state on rising edge
//   reset         in   asynchronous active-low reset
//   start         in   begin a dump (sampled only while idle)
//   abort         in   cancel a dump in progress
//   busA_probe    in   core register-file port A value
//   override_inst out  selects force_inst over instruction memory
//   force_inst    out  injected instruction word
//   busy          out  high whenever a dump is in progress
//   done          out  one-cycle pulse after the last handshake
//   dump_valid    out  dump_idx/dump_data valid
//   dump_ready    in   consumer accepts the current pair
//   dump_idx      out  register index of the current pair
//   dump_data     out  captured busA_probe value
//   checksum      out  running checksum (only with DUMP_CHECKSUM_EN)
module reg_dump_ctrl #(
  parameter int         DATA_W     = 32,
  parameter int         NREGS      = 32,
  parameter int         IDX_W      = $clog2(NREGS),
  parameter logic [5:0] OPCODE     = 6'b001000,
  parameter int         DRAIN_CYC  = 8,
  parameter int         SETTLE_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] busA_probe,
  output logic              override_inst,
  output logic [31:0]       force_inst,
  output logic              busy,
  output logic              done,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CNT_MAX = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_ISSUE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;

  // Register-read encoding: opcode, rs = index, all other fields zero.
  function automatic logic [31:0] encode_read(input logic [IDX_W-1:0] idx);
    logic [4:0] rs_s;
    rs_s = 5'(idx);
    return {OPCODE, rs_s, 21'd0};
  endfunction

  // Sequencer state machine; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      idx_r         <= '0;
      override_inst <= 1'b0;
      force_inst    <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      dump_valid    <= 1'b0;
      dump_idx      <= '0;
      dump_data     <= '0;
`ifdef DUMP_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else if (abort && (state_r != ST_IDLE)) begin
      // Abort beats handshakes and suppresses the done pulse.
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      idx_r         <= '0;
      override_inst <= 1'b0;
      force_inst    <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      dump_valid    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          override_inst <= 1'b0;
          force_inst    <= 32'd0;
          busy          <= 1'b0;
          done          <= 1'b0;
          dump_valid    <= 1'b0;
          if (start) begin
            state_r       <= ST_DRAIN;
            cnt_r         <= CNT_W'(DRAIN_CYC);
            idx_r         <= '0;
            override_inst <= 1'b1;
            busy          <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            checksum      <= '0;
`endif
          end
        end
        ST_DRAIN: begin
          // NOPs (all-zero word) flush in-flight instructions.
          if (cnt_r == CNT_W'(1)) begin
            state_r    <= ST_ISSUE;
            cnt_r      <= CNT_W'(SETTLE_CYC);
            force_inst <= encode_read(idx_r);
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_ISSUE: begin
          // busA is sampled only after the read has been held SETTLE_CYC cycles.
          if (cnt_r == CNT_W'(1)) begin
            state_r    <= ST_HOLD;
            cnt_r      <= '0;
            dump_data  <= busA_probe;
            dump_idx   <= idx_r;
            dump_valid <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            checksum   <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ dump_data;
`endif
            if (idx_r == IDX_W'(NREGS - 1)) begin
              state_r       <= ST_DONE;
              override_inst <= 1'b0;
              force_inst    <= 32'd0;
            end else begin
              state_r    <= ST_ISSUE;
              idx_r      <= idx_r + IDX_W'(1);
              cnt_r      <= CNT_W'(SETTLE_CYC);
              force_inst <= encode_read(idx_r + IDX_W'(1));
            end
          end
        end
        ST_DONE: begin
          // First cycle raises done. The second cycle drops done and busy together.
          if (!done) begin
            done <= 1'b1;
          end else begin
            done    <= 1'b0;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          cnt_r         <= '0;
          idx_r         <= '0;
          override_inst <= 1'b0;
          force_inst    <= 32'd0;
          busy          <= 1'b0;
          done          <= 1'b0;
          dump_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard testbench for reg_dump_ctrl (default parameters).
// The core is modelled as busA = 32'hA000_0000 + rs of the forced instruction.
module tb_reg_dump_ctrl;

  localparam int NREGS = 32;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] busA_probe;
  logic        override_inst;
  logic [31:0] force_inst;
  logic        busy;
  logic        done;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  reg_dump_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .busA_probe    (busA_probe),
    .override_inst (override_inst),
    .force_inst    (force_inst),
    .busy          (busy),
    .done          (done),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_idx      (dump_idx),
    .dump_data     (dump_data)
`ifdef DUMP_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  // Core model: the register file returns a value derived from rs.
  assign busA_probe = override_inst ? (32'hA000_0000 + {27'd0, force_inst[25:21]})
                                    : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int done_count = 0;
  int first_valid_cyc = -1;
  int done_cyc = -1;
  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  int c0 = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on handshake plus event timestamps.
  initial begin
    logic done_q, busy_q;
    exp_t e;
    done_q = 1'b0;
    busy_q = 1'b0;
    forever begin
      @(negedge clk);
      if (dump_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done && !done_q) begin
        done_count++;
        done_cyc = cyc;
      end
      if (busy && !busy_q) busy_rise_cyc = cyc;
      if (!busy && busy_q) busy_fall_cyc = cyc;
      done_q = done;
      busy_q = busy;
      if (dump_valid && dump_ready && !abort && reset) begin
        hs_count++;
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_pair", 64'(dump_idx), 64'hFFFF);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_idx", 64'(dump_idx), 64'(e.idx));
          check_eq("sb_data", 64'(dump_data), 64'(e.data));
          check_eq("sb_force_inst", 64'(force_inst), 64'({6'b001000, e.idx, 21'd0}));
        end
      end
    end
  end

  task automatic push_dump();
    exp_t e;
    for (int i = 0; i < NREGS; i++) begin
      e.idx  = 5'(i);
      e.data = 32'hA000_0000 + 32'(i);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Drive start after a posedge; E0 is the following posedge.
  task automatic do_start(input logic keep_high);
    first_valid_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    if (!keep_high) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int target;
    int n;
    target = done_count + 1;
    n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_count < target) check_eq(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_valid_idx(input logic [4:0] idx, input int budget, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(dump_valid && dump_idx == idx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(dump_valid && dump_idx == idx)) check_eq(tag, 64'd0, 64'd1);
  endtask

`ifdef DUMP_CHECKSUM_EN
  function automatic logic [31:0] model_checksum();
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < NREGS; i++) c = {c[30:0], c[31]} ^ (32'hA000_0000 + 32'(i));
    return c;
  endfunction
`endif

  initial begin
    int hs_before;
    int done_before;
    reset      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    dump_ready = 1'b1;

    // Reset state
    #12;
    check_eq("rst_override", 64'(override_inst), 64'd0);
    check_eq("rst_force", 64'(force_inst), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(dump_valid), 64'd0);
    check_eq("rst_idx_data", {27'd0, dump_idx, dump_data}, 64'd0);
    reset = 1'b1;
    wait_cycles(3);

    // Asynchronous reset in the middle of ISSUE
    do_start(1'b0);
    wait_cycles(9);
    check_eq("issue_busy", 64'(busy), 64'd1);
    check_eq("issue_override", 64'(override_inst), 64'd1);
    check_eq("issue_force_idx0", 64'(force_inst), 64'h2000_0000);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_override", 64'(override_inst), 64'd0);
    check_eq("async_rst_force", 64'(force_inst), 64'd0);
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    check_eq("async_rst_valid_done", {62'd0, dump_valid, done}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_cycles(6);
    check_eq("post_rst_idle_busy", 64'(busy), 64'd0);
    check_eq("post_rst_idle_override", 64'(override_inst), 64'd0);

    // Full dump with zero-wait consumer
    push_dump();
    do_start(1'b0);
    wait_done(400, "full_done_timeout");
    check_eq("full_first_valid_cyc", 64'(first_valid_cyc - c0), 64'd11);
    check_eq("full_done_cyc", 64'(done_cyc - c0), 64'd137);
    check_eq("full_busy_rise", 64'(busy_rise_cyc - c0), 64'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("full_busy_fall", 64'(busy_fall_cyc - done_cyc), 64'd1);
    check_eq("full_sb_empty", 64'(sb_q.size()), 64'd0);
`ifdef DUMP_CHECKSUM_EN
    check_eq("checksum_full", 64'(checksum), 64'(model_checksum()));
    wait_cycles(5);
    check_eq("checksum_held", 64'(checksum), 64'(model_checksum()));
`endif

    // Backpressure at idx 3
    wait_cycles(3);
    push_dump();
    do_start(1'b0);
    wait_valid_idx(5'd2, 200, "bp_idx2_timeout");
    @(posedge clk); #1;
    dump_ready = 1'b0;
    wait_valid_idx(5'd3, 50, "bp_idx3_timeout");
    for (int k = 0; k < 10; k++) begin
      check_eq("bp_valid", 64'(dump_valid), 64'd1);
      check_eq("bp_idx", 64'(dump_idx), 64'd3);
      check_eq("bp_data", 64'(dump_data), 64'hA000_0003);
      check_eq("bp_force", 64'(force_inst), 64'h2060_0000);
      @(negedge clk);
    end
    @(posedge clk); #1;
    dump_ready = 1'b1;
    wait_done(400, "bp_done_timeout");
    check_eq("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Abort in HOLD at idx 7, together with dump_ready
    wait_cycles(4);
    push_dump();
    do_start(1'b0);
    wait_valid_idx(5'd6, 200, "ab_idx6_timeout");
    @(posedge clk); #1;
    dump_ready = 1'b0;
    wait_valid_idx(5'd7, 50, "ab_idx7_timeout");
    @(posedge clk); #1;
    hs_before   = hs_count;
    done_before = done_count;
    dump_ready  = 1'b1;
    abort       = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("ab_busy", 64'(busy), 64'd0);
    check_eq("ab_override", 64'(override_inst), 64'd0);
    check_eq("ab_valid", 64'(dump_valid), 64'd0);
    check_eq("ab_hs_count", 64'(hs_count), 64'(hs_before));
    check_eq("ab_sb_left", 64'(sb_q.size()), 64'd25);
    sb_q.delete();
    wait_cycles(6);
    check_eq("ab_no_done", 64'(done_count), 64'(done_before));
    check_eq("ab_idle_busy", 64'(busy), 64'd0);

    // Restart after abort, with start held high during the dump
    push_dump();
    do_start(1'b1);
    wait_cycles(60);
    start = 1'b0;
    wait_done(400, "rs_done_timeout");
    check_eq("rs_first_valid_cyc", 64'(first_valid_cyc - c0), 64'd11);
    check_eq("rs_done_cyc", 64'(done_cyc - c0), 64'd137);
    check_eq("rs_sb_empty", 64'(sb_q.size()), 64'd0);
    wait_cycles(10);
    check_eq("rs_idle_after", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Hardware register-dump sequencer for the pipelined DLX core. It takes over the core's instruction input through the override path, drains the pipeline, and injects one register-read instruction per architectural register. After each injection it samples the core's busA probe and delivers every (index, value) pair on a valid/ready stream. This generalises the forced-instruction register dump into a reusable block with configurable register count, data width, drain and settle latencies, backpressure and abort.

## Interface
Parameters:
- DATA_W, 32, width of busA probe and dump data
- NREGS, 32, number of registers dumped (2..32), indices 0..NREGS-1
- IDX_W, $clog2(NREGS), index width
- OPCODE, 6'b001000, opcode placed in injected instructions
- DRAIN_CYC, 8, cycles of NOP injection before first register (≥1)
- SETTLE_CYC, 3, cycles each register instruction is held before busA is sampled (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin dump; sampled only in IDLE
- abort  in  1  cancel dump; honoured in any non-IDLE state
- busA_probe  in  DATA_W  core register-file port A value
- override_inst  out  1  selects force_inst over the instruction memory
- force_inst  out  32  injected instruction
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last handshake
- dump_valid  out  1  dump_idx/dump_data valid
- dump_ready  in  1  consumer accepts the current pair
- dump_idx  out  IDX_W  register index of the current pair
- dump_data  out  DATA_W  captured busA_probe value

## Operation
- States: IDLE, DRAIN, ISSUE, HOLD, DONE.
- IDLE: override_inst=0, force_inst=0, busy=0. start=1 → DRAIN, load cnt=DRAIN_CYC, idx=0.
- DRAIN: override_inst=1, force_inst=32'h0. Decrement cnt each cycle. On the last cycle → ISSUE with cnt=SETTLE_CYC.
- ISSUE: override_inst=1, force_inst={OPCODE, idx zero-extended to 5 bits, 21'b0}, so rs=idx. Decrement cnt. On the last cycle, the edge registers dump_data←busA_probe and dump_idx←idx, sets dump_valid=1, and moves to HOLD.
- HOLD: force_inst keeps the encoding for idx. dump_valid, dump_idx and dump_data stay stable until dump_ready=1.
  - On handshake with idx==NREGS-1 → DONE, dump_valid←0.
  - Otherwise idx←idx+1, cnt←SETTLE_CYC, dump_valid←0, → ISSUE.
- DONE: override_inst=0, done=1 for exactly one cycle, then → IDLE.
- abort=1 in DRAIN/ISSUE/HOLD/DONE → IDLE next edge. dump_valid, done and override_inst clear, and no done pulse is produced. abort has priority over dump_ready in the same cycle.
- start while busy is ignored. start and abort together in IDLE: start wins.
- idx never exceeds NREGS-1 and does not wrap.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, every output 0 (override_inst, force_inst, busy, done, dump_valid, dump_idx, dump_data), internal cnt/idx=0.
- Reset deasserted mid-dump: the block restarts in IDLE and waits for a fresh start.
- Let the start-sampling edge be E0. The first dump_valid rises after edge E0+DRAIN_CYC+SETTLE_CYC.
- With zero-wait consumer (dump_ready tied 1), each subsequent pair takes SETTLE_CYC+1 cycles.
- Total with zero-wait consumer: start to done = DRAIN_CYC + NREGS·(SETTLE_CYC+1) + 1 cycles.
- busy rises at the edge after start and falls at the edge after done.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - Adds output checksum [DATA_W-1:0]. It is cleared at start and, on each handshake, updated as checksum←(checksum rotated left by 1) XOR dump_data.
  - checksum is held stable from done until the next start. Reset value is 0.
- DUMP_CHECKSUM_EN undefined: the checksum port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert reset=0 mid-ISSUE with defaults → all outputs 0 immediately. After release the block stays IDLE until start.
- Full dump, dump_ready=1, defaults, busA_probe=32'hA000_0000+rs of force_inst:
  - first dump_valid after E11 with idx 0 / data 32'hA000_0000;
  - idx 31 / data 32'hA000_001F last;
  - done after E0+8+32·4+1;
  - force_inst for idx 5 = 32'h20A0_0000.
- Backpressure: dump_ready held 0 for 10 cycles at idx 3 → dump_idx=3 and dump_data stable, force_inst unchanged, no idx 4 issued until the handshake.
- Abort: abort=1 in HOLD at idx 7 together with dump_ready=1 → IDLE next edge, no handshake counted, no done pulse, override_inst=0.
- Restart: new start after abort → dump restarts at idx 0 with full DRAIN. start held high during a dump has no effect.
- DUMP_CHECKSUM_EN, NREGS=4, values 1,2,4,8 → checksum=32'h0000_0000 (((1<<1^2)<<1^4)<<1^8=0), held after done.
